// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit
// Iterative multiply/divide engine with HI/LO registers for the EX stage of
// a 5-stage MIPS pipeline. MULT/MULTU use one shift-add step per cycle,
// DIV/DIVU one restoring-division step per cycle, followed by a single
// sign-correction cycle that writes HI/LO. MTHI/MTLO write in one cycle.
//
// Ports:
//   Clk        rising-edge clock
//   Reset      asynchronous, active-low reset
//   start      EX-stage instruction is a muldiv op (qualified by op)
//   op         0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6/7 ignored
//   rs_data    multiplicand / dividend / MTxx source
//   rt_data    multiplier / divisor
//   flush      cancel any in-flight operation (wins over start)
//   use_req    ID-stage instruction reads HI/LO or is a muldiv op
//   busy       multicycle operation in progress
//   done       one-cycle pulse after HI/LO were written by MULT/DIV
//   stall_req  combinational hazard request for the ID stage
//   hi, lo     HI and LO registers
module mips_muldiv_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              flush,
    input  logic              use_req,
    output logic              busy,
    output logic              done,
    output logic              stall_req,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    // Two's-complement magnitude of v when neg is set, v otherwise.
    function automatic logic [DATA_W-1:0] mag_f(input logic [DATA_W-1:0] v,
                                                input logic neg);
        mag_f = neg ? (-v) : v;
    endfunction

    state_t              state_r;
    state_t              state_next_s;
    logic [CNT_W-1:0]    cnt_r;
    // opa_r: multiplicand magnitude in MUL, divisor magnitude in DIV.
    logic [DATA_W-1:0]   opa_r;
    // work_r: MUL = {partial upper, remaining multiplier};
    //         DIV = {partial remainder, dividend/quotient shift register}.
    logic [2*DATA_W-1:0] work_r;
    logic                neg_r;       // negate product / quotient at FIX
    logic                rem_neg_r;   // negate remainder at FIX
    logic                is_div_r;
    logic                div0_r;
    logic [DATA_W-1:0]   hi_r;
    logic [DATA_W-1:0]   lo_r;
    logic                busy_r;
    logic                done_r;

    logic                accept_s;
    logic                mthi_s;
    logic                mtlo_s;
    logic                commit_s;
    logic                last_s;
    logic                signed_op_s;
    logic [DATA_W-1:0]   rs_mag_s;
    logic [DATA_W-1:0]   rt_mag_s;

    logic [DATA_W:0]     mul_sum_s;
    logic [2*DATA_W-1:0] mul_next_s;
    logic [DATA_W:0]     div_shift_s;
    logic [DATA_W:0]     div_diff_s;
    logic [2*DATA_W-1:0] div_next_s;

    logic [2*DATA_W-1:0] prod_fix_s;
    logic [DATA_W-1:0]   quo_fix_s;
    logic [DATA_W-1:0]   rem_fix_s;
    logic [DATA_W-1:0]   hi_res_s;
    logic [DATA_W-1:0]   lo_res_s;

    assign last_s      = (cnt_r == CNT_W'(DATA_W - 1));
    assign signed_op_s = ~op[0];  // MULT (0) and DIV (2) are the signed ops
    assign rs_mag_s    = mag_f(rs_data, signed_op_s & rs_data[DATA_W-1]);
    assign rt_mag_s    = mag_f(rt_data, signed_op_s & rt_data[DATA_W-1]);

    // Shift-add: add multiplicand when the current multiplier LSB is set,
    // then shift the whole accumulator right; the carry enters the top bit.
    assign mul_sum_s  = {1'b0, work_r[2*DATA_W-1:DATA_W]}
                      + (work_r[0] ? {1'b0, opa_r} : {(DATA_W+1){1'b0}});
    assign mul_next_s = {mul_sum_s, work_r[DATA_W-1:1]};

    // Restoring division: shift the next dividend bit into the remainder and
    // keep the difference only if it did not borrow (bit DATA_W clear).
    assign div_shift_s = {work_r[2*DATA_W-1:DATA_W], work_r[DATA_W-1]};
    assign div_diff_s  = div_shift_s - {1'b0, opa_r};
    assign div_next_s  = div_diff_s[DATA_W]
                       ? {div_shift_s[DATA_W-1:0], work_r[DATA_W-2:0], 1'b0}
                       : {div_diff_s[DATA_W-1:0],  work_r[DATA_W-2:0], 1'b1};

    // Sign correction. With a zero divisor the remainder path already yields
    // the original rs value; only the quotient needs forcing to all ones.
    assign prod_fix_s = neg_r ? (-work_r) : work_r;
    assign quo_fix_s  = div0_r ? {DATA_W{1'b1}}
                      : (neg_r ? (-work_r[DATA_W-1:0]) : work_r[DATA_W-1:0]);
    assign rem_fix_s  = rem_neg_r ? (-work_r[2*DATA_W-1:DATA_W])
                                  : work_r[2*DATA_W-1:DATA_W];
    assign hi_res_s   = is_div_r ? rem_fix_s : prod_fix_s[2*DATA_W-1:DATA_W];
    assign lo_res_s   = is_div_r ? quo_fix_s : prod_fix_s[DATA_W-1:0];

    assign stall_req = use_req & (busy_r | (start & (op <= 3'd3)));
    assign busy      = busy_r;
    assign done      = done_r;
    assign hi        = hi_r;
    assign lo        = lo_r;

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state and control strobes; flush overrides everything.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        mthi_s       = 1'b0;
        mtlo_s       = 1'b0;
        commit_s     = 1'b0;
        if (flush) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            3'd0, 3'd1: begin
                                state_next_s = ST_MUL;
                                accept_s     = 1'b1;
                            end
                            3'd2, 3'd3: begin
                                state_next_s = ST_DIV;
                                accept_s     = 1'b1;
                            end
                            3'd4:    mthi_s       = 1'b1;
                            3'd5:    mtlo_s       = 1'b1;
                            default: state_next_s = ST_IDLE;
                        endcase
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (last_s) begin
                        state_next_s = ST_FIX;
                    end else begin
                        state_next_s = ST_MUL;
                    end
                end
                ST_DIV: begin
                    if (last_s) begin
                        state_next_s = ST_FIX;
                    end else begin
                        state_next_s = ST_DIV;
                    end
                end
                ST_FIX: begin
                    commit_s     = 1'b1;
                    state_next_s = ST_IDLE;
                end
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // Operand latch and per-cycle iteration of the datapath.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_r     <= {CNT_W{1'b0}};
            opa_r     <= {DATA_W{1'b0}};
            work_r    <= {(2*DATA_W){1'b0}};
            neg_r     <= 1'b0;
            rem_neg_r <= 1'b0;
            is_div_r  <= 1'b0;
            div0_r    <= 1'b0;
        end else if (accept_s) begin
            cnt_r     <= {CNT_W{1'b0}};
            neg_r     <= signed_op_s & (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]);
            rem_neg_r <= signed_op_s & rs_data[DATA_W-1];
            is_div_r  <= op[1];
            div0_r    <= op[1] & (rt_data == {DATA_W{1'b0}});
            if (op[1]) begin
                work_r <= {{DATA_W{1'b0}}, rs_mag_s};
                opa_r  <= rt_mag_s;
            end else begin
                work_r <= {{DATA_W{1'b0}}, rt_mag_s};
                opa_r  <= rs_mag_s;
            end
        end else if (state_r == ST_MUL) begin
            cnt_r  <= cnt_r + CNT_W'(1);
            work_r <= mul_next_s;
        end else if (state_r == ST_DIV) begin
            cnt_r  <= cnt_r + CNT_W'(1);
            work_r <= div_next_s;
        end else begin
            cnt_r  <= cnt_r;
            work_r <= work_r;
        end
    end

    // HI/LO architectural registers: MULT/DIV results or MTHI/MTLO writes.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hi_r <= {DATA_W{1'b0}};
            lo_r <= {DATA_W{1'b0}};
        end else if (commit_s) begin
            hi_r <= hi_res_s;
            lo_r <= lo_res_s;
        end else if (mthi_s) begin
            hi_r <= rs_data;
        end else if (mtlo_s) begin
            lo_r <= rs_data;
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    // Registered status outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            done_r <= commit_s;
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
module tb_mips_muldiv_unit;

    logic        Clk;
    logic        Reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        use_req;
    logic        busy;
    logic        done;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        start8;
    logic [2:0]  op8;
    logic [7:0]  rs8;
    logic [7:0]  rt8;
    logic        flush8;
    logic        use8;
    logic        busy8;
    logic        done8;
    logic        stall8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;

    int pass_cnt  = 0;
    int check_cnt = 0;

    mips_muldiv_unit #(.DATA_W(32)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
        .use_req(use_req), .busy(busy), .done(done),
        .stall_req(stall_req), .hi(hi), .lo(lo)
    );

    mips_muldiv_unit #(.DATA_W(8)) dut8 (
        .Clk(Clk), .Reset(Reset), .start(start8), .op(op8),
        .rs_data(rs8), .rt_data(rt8), .flush(flush8),
        .use_req(use8), .busy(busy8), .done(done8),
        .stall_req(stall8), .hi(hi8), .lo(lo8)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        check_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Issue one MULT/DIV op with use_req held, then check latency, stall,
    // done pulse and the HI/LO result.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] hi0;
        int nb;
        int ns;
        @(negedge Clk);
        hi0     = hi;
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        use_req = 1'b1;
        #1 check_val({tag, " stall_at_start"}, 64'(stall_req), 64'd1);
        @(negedge Clk);
        start = 1'b0;
        nb = 0;
        ns = 0;
        while (busy && nb < 60) begin
            nb++;
            if (stall_req) ns++;
            if (nb == 5) check_val({tag, " hi_stable"}, 64'(hi), 64'(hi0));
            @(negedge Clk);
        end
        check_val({tag, " busy_cycles"}, 64'(nb), 64'd33);
        check_val({tag, " stall_cycles"}, 64'(ns), 64'd33);
        check_val({tag, " done"}, 64'(done), 64'd1);
        check_val({tag, " stall_in_done"}, 64'(stall_req), 64'd0);
        check_val({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check_val({tag, " lo"}, 64'(lo), 64'(exp_lo));
        use_req = 1'b0;
        @(negedge Clk);
        check_val({tag, " done_cleared"}, 64'(done), 64'd0);
    endtask

    initial begin
        int nb;
        int nd;
        Reset   = 1'b1;
        start   = 1'b0; op = 3'd0; rs_data = 32'd0; rt_data = 32'd0;
        flush   = 1'b0; use_req = 1'b0;
        start8  = 1'b0; op8 = 3'd0; rs8 = 8'd0; rt8 = 8'd0;
        flush8  = 1'b0; use8 = 1'b0;
        #3 Reset = 1'b0;
        @(negedge Clk);
        check_val("rst busy", 64'(busy), 64'd0);
        check_val("rst done", 64'(done), 64'd0);
        check_val("rst hi", 64'(hi), 64'd0);
        check_val("rst lo", 64'(lo), 64'd0);
        Reset = 1'b1;
        @(negedge Clk);
        use_req = 1'b1;
        #1 check_val("idle use_req stall", 64'(stall_req), 64'd0);
        use_req = 1'b0;

        run_op("multu max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult -3*7", 3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("div -7/2", 3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div 7/-2", 3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run_op("divu 100/7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("divu by0", 3'd3, 32'h0000000A, 32'h0, 32'h0000000A, 32'hFFFFFFFF);
        run_op("div -7 by0", 3'd2, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run_op("div ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

        // 8-bit instance: MULT -128 * -128 = 0x4000
        @(negedge Clk);
        start8 = 1'b1; op8 = 3'd0; rs8 = 8'h80; rt8 = 8'h80;
        @(negedge Clk);
        start8 = 1'b0;
        nb = 0;
        while (busy8 && nb < 30) begin
            nb++;
            @(negedge Clk);
        end
        check_val("w8 busy_cycles", 64'(nb), 64'd9);
        check_val("w8 done", 64'(done8), 64'd1);
        check_val("w8 hi", 64'(hi8), 64'h40);
        check_val("w8 lo", 64'(lo8), 64'h00);

        // MTHI/MTLO preset, then flush a DIV mid-flight
        @(negedge Clk);
        start = 1'b1; op = 3'd4; rs_data = 32'h12345678;
        @(negedge Clk);
        op = 3'd5;
        @(negedge Clk);
        start = 1'b0;
        check_val("mthi", 64'(hi), 64'h12345678);
        check_val("mtlo", 64'(lo), 64'h12345678);
        check_val("mtxx no busy", 64'(busy), 64'd0);
        start = 1'b1; op = 3'd2; rs_data = 32'd100; rt_data = 32'd3;
        @(negedge Clk);
        start = 1'b0;
        repeat (9) @(negedge Clk);
        check_val("flush pre busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge Clk);
        flush = 1'b0;
        check_val("flush busy", 64'(busy), 64'd0);
        check_val("flush hi", 64'(hi), 64'h12345678);
        check_val("flush lo", 64'(lo), 64'h12345678);
        nd = 0;
        repeat (40) begin
            if (done) nd++;
            @(negedge Clk);
        end
        check_val("flush no done", 64'(nd), 64'd0);
        check_val("flush hi later", 64'(hi), 64'h12345678);

        // flush together with MTHI drops the write
        flush = 1'b1; start = 1'b1; op = 3'd4; rs_data = 32'hDEADBEEF;
        @(negedge Clk);
        flush = 1'b0; start = 1'b0;
        check_val("flush+mthi", 64'(hi), 64'h12345678);
        start = 1'b1; op = 3'd5; rs_data = 32'h0000ABCD;
        @(negedge Clk);
        start = 1'b0;
        check_val("mtlo after flush", 64'(lo), 64'h0000ABCD);

        // reserved op has no effect
        start = 1'b1; op = 3'd6; rs_data = 32'h55555555;
        @(negedge Clk);
        start = 1'b0;
        check_val("op6 busy", 64'(busy), 64'd0);
        check_val("op6 hi", 64'(hi), 64'h12345678);

        // async reset between edges mid-MUL
        start = 1'b1; op = 3'd0; rs_data = 32'd5; rt_data = 32'd6;
        @(negedge Clk);
        start = 1'b0;
        repeat (4) @(negedge Clk);
        check_val("pre-reset busy", 64'(busy), 64'd1);
        #2 Reset = 1'b0;
        #1;
        check_val("async busy", 64'(busy), 64'd0);
        check_val("async done", 64'(done), 64'd0);
        check_val("async hi", 64'(hi), 64'd0);
        check_val("async lo", 64'(lo), 64'd0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
